// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-address generator with prioritised redirects, fetch handshake, stall and a circular return-address stack
module pc_fetch_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int STEP = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_target,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            ras_push_en,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop_en,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic            align_err,
  output logic            ras_underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  logic [XLEN-1:0] pc_q, pc_d;
  logic pc_valid_q, pc_valid_d, flush_q, flush_d, align_err_q, align_err_d, ras_underflow_q, ras_underflow_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic take_trap, take_br, ras_ok, pop_hit, push, acc, jump;
  logic [XLEN-1:0] target;
  always_comb begin
    take_trap = pc_valid_q & trap_en;
    take_br = pc_valid_q & ~trap_en & redirect_en;
    ras_ok = pc_valid_q & ~trap_en & ~redirect_en;
    pop_hit = ras_ok & ras_pop_en & (cnt_q != '0);
    push = ras_ok & ras_push_en;
    acc = pc_valid_q & fetch_ready & ~stall;
    jump = take_trap | take_br | pop_hit;
    target = take_trap ? trap_target : take_br ? redirect_target : ras_q[ptr_q];
    pc_d = jump ? {target[XLEN-1:2], 2'b00} : acc ? pc_q + XLEN'(STEP) : pc_q;
    pc_valid_d = 1'b1;
    flush_d = jump;
    align_err_d = jump & |target[1:0];
    ras_underflow_d = ras_ok & ras_pop_en & (cnt_q == '0);
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    // a push alongside a successful pop replaces the slot just read
    if (take_trap) cnt_d = '0;
    else if (push && pop_hit) ras_d[ptr_q] = ras_push_addr;
    else if (push) begin
      ptr_d = ptr_q + PW'(1);
      ras_d[ptr_d] = ras_push_addr;
      cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + CW'(1);
    end else if (pop_hit) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      flush_q <= 1'b0;
      align_err_q <= 1'b0;
      ras_underflow_q <= 1'b0;
      ras_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q <= flush_d;
      align_err_q <= align_err_d;
      ras_underflow_q <= ras_underflow_d;
      ras_q <= ras_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign pc = pc_q;
  assign pc_valid = pc_valid_q;
  assign flush = flush_q;
  assign align_err = align_err_q;
  assign ras_underflow = ras_underflow_q;
endmodule
